// File: rtl/day_scenario_gen.sv
// Pseudo-random "day" stimulus source and pass/fail collector for the commute/exam/presentation chain.
// Latency: 4 cycles per day with the consumer always ready, plus 1 DONE cycle (NUM_DAYS=8 -> done 33 cycles after start).
// Backpressure: holds the vector stable with vec_valid high in PRESENT until vec_ready; no timeout.
module day_scenario_gen #(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          NUM_DAYS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_vec_valid,
    input  logic                i_vec_ready,
    output logic [6:0]          o_speed,
    output logic [6:0]          o_random1,
    output logic [6:0]          o_effort,
    output logic [4:0]          o_hard,
    output logic [4:0]          o_random2,
    output logic [2:0]          o_slide,
    output logic [2:0]          o_timing,
    output logic [2:0]          o_luck3,
    output logic [1:0]          o_breakfast,
    output logic [1:0]          o_movement,
    output logic                o_weather,
    input  logic                i_pass3,
    output logic [5:0]          o_pass_count,
    output logic [NUM_DAYS-1:0] o_pass_hist,
    output logic [4:0]          o_day_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN0,
        S_GEN1,
        S_GEN2,
        S_PRESENT,
        S_DONE
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [4:0]  LAST_DAY  = 5'(NUM_DAYS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_next;
    logic                w_gen;
    logic                w_accept;
    logic                w_start_ok;
    logic                w_busy;
    logic                w_done;
    logic                w_vec_valid;
    logic [5:0]          r_pass_count;
    logic [NUM_DAYS-1:0] r_pass_hist;
    logic [4:0]          r_day_idx;
    logic [6:0]          r_speed, r_random1, r_effort;
    logic [4:0]          r_hard, r_random2;
    logic [2:0]          r_slide, r_timing, r_luck3;
    logic [1:0]          r_breakfast, r_movement;
    logic                r_weather;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_gen       = (r_state == S_GEN0) || (r_state == S_GEN1) || (r_state == S_GEN2);
    assign w_accept    = (r_state == S_PRESENT) && i_vec_ready;
    assign w_start_ok  = (r_state == S_IDLE) && i_start;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state and state-decoded handshake/status outputs.
    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_vec_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) w_next = S_GEN0;
            end
            S_GEN0:    w_next = S_GEN1;
            S_GEN1:    w_next = S_GEN2;
            S_GEN2:    w_next = S_PRESENT;
            S_PRESENT: begin
                w_vec_valid = 1'b1;
                if (i_vec_ready) w_next = (r_day_idx == LAST_DAY) ? S_DONE : S_GEN0;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // LFSR steps once per GEN cycle; it survives across runs and only reset reloads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_lfsr <= LFSR_INIT;
        else if (w_gen) r_lfsr <= w_lfsr_next;
    end

    // Vector fields are captured from the LFSR in three slices and held until the next GEN0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_speed     <= '0;
            r_random1   <= '0;
            r_breakfast <= '0;
            r_effort    <= '0;
            r_hard      <= '0;
            r_movement  <= '0;
            r_weather   <= 1'b0;
            r_random2   <= '0;
            r_slide     <= '0;
            r_timing    <= '0;
            r_luck3     <= '0;
        end else begin
            case (r_state)
                S_GEN0: begin
                    r_speed     <= r_lfsr[6:0];
                    r_random1   <= r_lfsr[13:7];
                    r_breakfast <= r_lfsr[15:14];
                end
                S_GEN1: begin
                    r_effort    <= r_lfsr[6:0];
                    r_hard      <= r_lfsr[11:7];
                    r_movement  <= r_lfsr[13:12];
                    r_weather   <= r_lfsr[14];
                end
                S_GEN2: begin
                    r_random2   <= r_lfsr[4:0];
                    r_slide     <= r_lfsr[7:5];
                    r_timing    <= r_lfsr[10:8];
                    r_luck3     <= r_lfsr[13:11];
                end
                default: ;
            endcase
        end
    end

    // Result collection: cleared on an accepted start, updated on each vector handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pass_count <= '0;
            r_pass_hist  <= '0;
            r_day_idx    <= '0;
        end else if (w_start_ok) begin
            r_pass_count <= '0;
            r_pass_hist  <= '0;
            r_day_idx    <= '0;
        end else if (w_accept) begin
            r_pass_count <= r_pass_count + {5'd0, i_pass3};
            for (int d = 0; d < NUM_DAYS; d++) begin
                if (r_day_idx == 5'(d)) r_pass_hist[d] <= i_pass3;
            end
            if (r_day_idx != LAST_DAY) r_day_idx <= r_day_idx + 5'd1;
        end
    end

    assign o_busy       = w_busy;
    assign o_done       = w_done;
    assign o_vec_valid  = w_vec_valid;
    assign o_speed      = r_speed;
    assign o_random1    = r_random1;
    assign o_effort     = r_effort;
    assign o_hard       = r_hard;
    assign o_random2    = r_random2;
    assign o_slide      = r_slide;
    assign o_timing     = r_timing;
    assign o_luck3      = r_luck3;
    assign o_breakfast  = r_breakfast;
    assign o_movement   = r_movement;
    assign o_weather    = r_weather;
    assign o_pass_count = r_pass_count;
    assign o_pass_hist  = r_pass_hist;
    assign o_day_idx    = r_day_idx;

endmodule

// File: tb/tb_day_scenario_gen.sv
// Directed bench for day_scenario_gen: expected day vectors queued at start, compared at each handshake.
// Covers reset values, day-0 vector, latency, pass history patterns, stall, ignored start, mid-run reset.
// Consumer readiness and pass3 are driven from the bench; stalls hold vec_ready low.
module tb_day_scenario_gen;

    localparam int          NUM_DAYS = 8;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                busy;
    logic                done;
    logic                vec_valid;
    logic                vec_ready;
    logic [6:0]          speed, random1, effort;
    logic [4:0]          hard, random2;
    logic [2:0]          slide, timing, luck3;
    logic [1:0]          breakfast, movement;
    logic                weather;
    logic                pass3;
    logic [5:0]          pass_count;
    logic [NUM_DAYS-1:0] pass_hist;
    logic [4:0]          day_idx;
    logic [44:0]         obs_vec;

    int                  checks = 0;
    int                  errors = 0;
    logic [15:0]         m_lfsr;
    logic [44:0]         sb[$];
    logic [44:0]         day0_exp;

    day_scenario_gen #(.SEED(SEED), .NUM_DAYS(NUM_DAYS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy), .o_done(done), .o_vec_valid(vec_valid), .i_vec_ready(vec_ready),
        .o_speed(speed), .o_random1(random1), .o_effort(effort),
        .o_hard(hard), .o_random2(random2),
        .o_slide(slide), .o_timing(timing), .o_luck3(luck3),
        .o_breakfast(breakfast), .o_movement(movement), .o_weather(weather),
        .i_pass3(pass3), .o_pass_count(pass_count), .o_pass_hist(pass_hist), .o_day_idx(day_idx)
    );

    assign obs_vec = {speed, random1, effort, hard, random2, slide, timing, luck3,
                      breakfast, movement, weather};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Expected vector for one day starting from LFSR value l0.
    function automatic logic [44:0] day_vec(input logic [15:0] l0);
        logic [15:0] l1, l2;
        l1 = step(l0);
        l2 = step(l1);
        return {l0[6:0], l0[13:7], l1[6:0], l1[11:7], l2[4:0], l2[7:5], l2[10:8], l2[13:11],
                l0[15:14], l1[13:12], l1[14]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_valid"}, 64'(vec_valid), 64'd0);
        chk({tag, "_vec"}, 64'(obs_vec), 64'd0);
        chk({tag, "_count"}, 64'(pass_count), 64'd0);
        chk({tag, "_hist"}, 64'(pass_hist), 64'd0);
        chk({tag, "_day"}, 64'(day_idx), 64'd0);
    endtask

    // One run: queue expected vectors, act as the consumer, compare at every handshake.
    task automatic run(input logic [7:0] pat, input int stall_day, input int stall_n,
                       input int pulse_day, input int rst_day, input bit fresh);
        logic [15:0] l;
        int day, ph, cyc, stall_left;
        bit prev_hs, finished;
        l = m_lfsr;
        for (int d = 0; d < NUM_DAYS; d++) begin
            sb.push_back(day_vec(l));
            l = step(step(step(l)));
        end
        day = 0; ph = 0; stall_left = stall_n; prev_hs = 0; finished = 0;
        @(negedge clk);
        start = 1'b1; vec_ready = 1'b1; pass3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!finished) begin
            start = 1'b0;
            if (cyc == 1) chk("busy_rise", 64'(busy), 64'd1);
            if (prev_hs) chk("valid_drop", 64'(vec_valid), 64'd0);
            prev_hs = 0;
            if (done) begin
                chk("done_latency", 64'(cyc), 64'(NUM_DAYS * 4 + 1 + stall_n));
                finished = 1;
            end else if (vec_valid) begin
                if (day == stall_day && stall_left > 0) begin
                    vec_ready = 1'b0;
                    chk("stall_vec", 64'(obs_vec), 64'(sb[0]));
                    chk("stall_day", 64'(day_idx), 64'(day));
                    stall_left--;
                end else begin
                    vec_ready = 1'b1;
                    pass3 = pat[day];
                    chk("day_idx", 64'(day_idx), 64'(day));
                    if (day == 0 && fresh) begin
                        chk("day0_const", 64'(obs_vec), 64'(day0_exp));
                        chk("lfsr_after_day0", 64'(dut.r_lfsr), 64'h670F);
                    end
                    chk("day_vec", 64'(obs_vec), 64'(sb.pop_front()));
                    day++;
                    ph = 0;
                    prev_hs = 1;
                end
            end else begin
                if (day == pulse_day && ph == 1) start = 1'b1;
                if (day == rst_day && ph == 1) begin
                    rst_n = 1'b0;
                    #1;
                    chk_all_zero("midrst");
                    chk("midrst_lfsr", 64'(dut.r_lfsr), 64'(SEED));
                    for (int k = 0; k < 2; k++) begin
                        @(negedge clk);
                        chk("midrst_nodone", 64'(done), 64'd0);
                    end
                    rst_n = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        chk("postrst_idle", 64'({busy, done, vec_valid}), 64'd0);
                    end
                    m_lfsr = SEED;
                    sb.delete();
                    return;
                end
                ph++;
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
                if (cyc > 300) begin
                    chk("timeout", 64'(cyc), 64'd0);
                    finished = 1;
                end
            end
        end
        chk("pass_count", 64'(pass_count), 64'($countones(pat)));
        chk("pass_hist", 64'(pass_hist), 64'(pat));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        m_lfsr = l;
        @(negedge clk);
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        day0_exp = {7'd97, 7'd89, 7'd67, 5'd19, 5'd7, 3'd4, 3'd3, 3'd6, 2'd2, 2'd1, 1'b1};
        m_lfsr = SEED;
        rst_n = 1'b0; start = 1'b0; vec_ready = 1'b0; pass3 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_lfsr", 64'(dut.r_lfsr), 64'(SEED));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // All pass, consumer always ready.
        run(8'hFF, -1, 0, -1, -1, 1'b1);
        // Alternating pass, 10-cycle stall on day 2, stray start during day 3 GEN1.
        run(8'h55, 2, 10, 3, -1, 1'b0);
        // Reset during day 5.
        run(8'hFF, -1, 0, -1, 5, 1'b0);
        // Fresh run after reset repeats the seed sequence.
        run(8'h55, -1, 0, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/day_scenario_gen.md
Name: day_scenario_gen

Overview:
- Sequential stimulus source and result collector for the three-stage pass/fail evaluation chain (commute, exam, presentation); it sits on the producer side of that chain's input bundle.
- Generates one pseudo-random "day" per transaction from a 16-bit LFSR, presents the full input vector with a valid/ready handshake, and samples the returned pass3 on handshake.
- Runs NUM_DAYS transactions per start; accumulates pass count and a per-day pass history.

Parameters:
- SEED, 16'hACE1, LFSR reset value; 16'h0000 is replaced by 16'h0001.
- NUM_DAYS, 8, days per run; legal range 1..32.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a run; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until DONE is exited
- done  output  1  one-cycle pulse when the run completes
- vec_valid  output  1  input vector is stable and valid
- vec_ready  input  1  consumer accepts the vector; pass3 is valid in the same cycle
- speed, random1, effort  output  7 each  stage inputs
- hard, random2  output  5 each  stage inputs
- slide, timing, luck3  output  3 each  stage inputs
- breakfast, movement  output  2 each  stage inputs
- weather  output  1  stage input
- pass3  input  1  result from the evaluation chain for the presented vector
- pass_count  output  6  passes in the current or last run
- pass_hist  output  NUM_DAYS  bit d = pass3 of day d
- day_idx  output  5  index of the day being generated or presented

Behaviour:
- Reset: all outputs are 0. The LFSR loads SEED. The FSM enters IDLE.
- LFSR: 16-bit Fibonacci register. Next value = {L[14:0], L[15]^L[13]^L[12]^L[10]}. It advances only on the final cycle of each GEN state. Its state persists across runs; it is reloaded only by reset.
- FSM states: IDLE, GEN0, GEN1, GEN2, PRESENT, DONE.
- IDLE:
  - start=1 moves to GEN0.
  - On that same edge, clear pass_count, pass_hist and day_idx.
  - busy rises on the next cycle.
- GEN0 (1 cycle, uses the current LFSR value L): speed=L[6:0]; random1=L[13:7]; breakfast=L[15:14].
- GEN1 (1 cycle): effort=L[6:0]; hard=L[11:7]; movement=L[13:12]; weather=L[14].
- GEN2 (1 cycle): random2=L[4:0]; slide=L[7:5]; timing=L[10:8]; luck3=L[13:11].
- PRESENT:
  - vec_valid=1 and all vector outputs are held constant.
  - The state waits while vec_ready=0; there is no timeout.
  - On vec_valid&vec_ready: pass_hist[day_idx]<=pass3 and pass_count<=pass_count+pass3.
  - Then, if day_idx==NUM_DAYS-1, go to DONE; otherwise day_idx increments and the FSM goes to GEN0.
  - vec_valid drops on the cycle after acceptance.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE.
- Latency with vec_ready tied high: 4 cycles per day, plus 1 cycle for DONE. NUM_DAYS=8 gives done 33 cycles after the start edge.
- Vector outputs retain the last day's values after a run, until the next GEN0.
- start while busy is ignored. start and done in the same cycle: start is ignored because the FSM is not in IDLE.
- Reset mid-run: the run aborts immediately, all outputs return to 0, and the LFSR returns to SEED. No done pulse is issued.
- Width rules: pass_count saturates naturally because NUM_DAYS≤32 fits in 6 bits. day_idx never exceeds NUM_DAYS-1.

Test Plan:
- Reset, then start with vec_ready=1 and SEED=ACE1. Day 0 must present:
  - speed=97, random1=89, breakfast=2
  - effort=67, hard=19, movement=1, weather=1
  - random2=7, slide=4, timing=3, luck3=6
  - The LFSR must then equal 16'h670F.
- Tie pass3=1 and vec_ready=1, NUM_DAYS=8 → done pulses 33 cycles after start, pass_count=8, pass_hist=8'hFF, busy=0 afterwards.
- Drive pass3 alternating 1,0,1,… per accepted day → pass_hist=8'h55, pass_count=4.
- Hold vec_ready=0 for 10 cycles in day 2's PRESENT → vec_valid stays high, vector unchanged, day_idx=2. The handshake completes on the first cycle vec_ready=1.
- Pulse start during GEN1 of day 3 → no effect on day_idx, counts or LFSR sequence.
- Assert rst_n=0 during day 5, then start a new run → outputs 0 during reset, no done pulse, and the new run's day 0 again equals the values in the first scenario.
